// File: rtl/cpu_clkgen.sv
// rtl/cpu_clkgen.sv - phase/clock sequencer for the CPU: run/step/halt gating of controller, ALU and fetch strobes
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst_         asynchronous active-low reset
//   run          level, request continuous execution
//   step         pulse, request exactly one instruction cycle
//   halt         from the CPU controller, stop at the next instruction boundary
//   cntrl_clk    controller clock, clk/2 while active
//   alu_clk      one 2-cycle-high pulse per instruction cycle (phases 12-13)
//   fetch        high during the first half of each instruction cycle
//   busy         sequencer is in RUN or STEP
//   halted       sequencer is in HALTED
//   instr_done   one-cycle pulse after each completed instruction cycle
//   instr_count  completed instruction cycles, saturating at all-ones

module cpu_clkgen #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             run,
    input  logic             step,
    input  logic             halt,
    output logic             cntrl_clk,
    output logic             alu_clk,
    output logic             fetch,
    output logic             busy,
    output logic             halted,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_STEP   = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [3:0]       ph;
    logic [3:0]       ph_nxt;
    logic             halt_seen;
    logic             halt_seen_nxt;
    logic             active;
    logic             active_nxt;
    logic             wrap;
    logic [CNT_W-1:0] count_nxt;

    always_comb begin
        active        = (state == S_RUN) || (state == S_STEP);
        wrap          = active && (ph == 4'hf);
        state_nxt     = state;
        ph_nxt        = ph;
        halt_seen_nxt = halt_seen;
        count_nxt     = instr_count;

        case (state)
            S_IDLE: begin
                // run has priority over step; phase stays 0 on the entry edge
                ph_nxt = 4'd0;
                if (run) begin
                    state_nxt = S_RUN;
                end else if (step) begin
                    state_nxt = S_STEP;
                end
            end
            S_RUN, S_STEP: begin
                if (halt) begin
                    halt_seen_nxt = 1'b1;
                end
                ph_nxt = ph + 4'd1;
                if (wrap) begin
                    if (instr_count != {CNT_W{1'b1}}) begin
                        count_nxt = instr_count + CNT_W'(1);
                    end
                    // halt sampled on the wrap edge itself counts as well
                    if (halt_seen || halt) begin
                        state_nxt = S_HALTED;
                    end else if ((state == S_RUN) && run) begin
                        state_nxt = S_RUN;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                // HALTED: only reset leaves this state
                ph_nxt = 4'd0;
            end
        endcase

        active_nxt = (state_nxt == S_RUN) || (state_nxt == S_STEP);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state       <= S_IDLE;
            ph          <= 4'd0;
            halt_seen   <= 1'b0;
            cntrl_clk   <= 1'b0;
            alu_clk     <= 1'b0;
            fetch       <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            instr_done  <= 1'b0;
            instr_count <= '0;
        end else begin
            state       <= state_nxt;
            ph          <= ph_nxt;
            halt_seen   <= halt_seen_nxt;
            // outputs are registered from the next state/phase so each flop
            // always matches the decode of the state/phase it sits beside
            cntrl_clk   <= active_nxt & ph_nxt[0];
            fetch       <= active_nxt & ~ph_nxt[3];
            alu_clk     <= active_nxt & ((ph_nxt == 4'd12) || (ph_nxt == 4'd13));
            busy        <= active_nxt;
            halted      <= (state_nxt == S_HALTED);
            instr_done  <= wrap;
            instr_count <= count_nxt;
        end
    end

endmodule
